led_shift_out_driver: RTL and testbench

Serialises the 8-bit LED value produced by the Nios II LED PIO (`out_port`) onto an external 74HC595-style shift register chain using SER/SRCLK/RCLK. It sits directly downstream of the PIO: whenever the parallel value changes, it shifts out one frame and latches it, freeing FPGA pins and giving the LEDs glitch-free updates. Intermediate values written during a frame are coalesced; only the latest value is sent next.

---
 rtl/led_shift_pkg.sv | 29 ++
 rtl/led_shift_tick.sv | 38 +++
 rtl/led_shift_out_driver.sv | 130 +++++++++++++
 tb/tb_led_shift_out_driver.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_shift_pkg.sv
// Shared types and width helpers for the LED shift-register output driver.
package led_shift_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH_HI,
        LATCH_LO
    } led_shift_state_t;

    localparam int unsigned MAX_DATA_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_CLK_DIV    = 4;

    // bit_cnt must be able to hold DATA_WIDTH itself
    function automatic int unsigned bit_cnt_width(input int unsigned data_width);
        return $clog2(data_width + 1);
    endfunction

    // div_cnt is kept at least 1 bit wide so CLK_DIV=1 still elaborates
    function automatic int unsigned div_cnt_width(input int unsigned clk_div);
        return (clk_div <= 1) ? 1 : $clog2(clk_div);
    endfunction

    localparam int unsigned DEF_BIT_CNT_W = bit_cnt_width(DEF_DATA_WIDTH);
    localparam int unsigned DEF_DIV_CNT_W = div_cnt_width(DEF_CLK_DIV);

endpackage

// File: rtl/led_shift_tick.sv
// Half-period timer: registered tick on the last cycle of every CLK_DIV-cycle phase.
module led_shift_tick
    import led_shift_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int unsigned DIV_W = div_cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0] LAST_CNT = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_cnt_d;

    // Count restarts at zero whenever a new phase begins or the timer is idle
    always_comb begin
        div_cnt_d = '0;
        if (en && !restart && (div_cnt != LAST_CNT)) begin
            div_cnt_d = div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= div_cnt_d;
            tick    <= en && (div_cnt_d == LAST_CNT);
        end
    end

endmodule

// File: rtl/led_shift_out_driver.sv
// Serialises a parallel LED value onto a 74HC595-style chain (SER/SRCLK/RCLK),
// resending only when the value changes; intermediate values are coalesced.
module led_shift_out_driver
    import led_shift_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ser,
    output logic                  srclk,
    output logic                  rclk,
    output logic                  busy
);

    localparam int unsigned BIT_CNT_W = bit_cnt_width(DATA_WIDTH);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    if (CLK_DIV < 1 || DATA_WIDTH < 1 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_param
        $error("led_shift_out_driver: CLK_DIV must be >=1 and DATA_WIDTH within 1..32");
    end

    led_shift_state_t      state, next_state;
    logic [DATA_WIDTH-1:0] shift_reg, shift_d;
    logic [DATA_WIDTH-1:0] last_sent, last_sent_d;
    logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_d;
    logic                  init_pending, init_d;
    logic                  ser_d, srclk_d, rclk_d, busy_d;
    logic                  tick;
    logic                  start_c;
    logic                  tick_en_c;
    logic                  tick_restart_c;

    assign start_c        = init_pending || (data_in != last_sent);
    assign tick_en_c      = (next_state != IDLE);
    assign tick_restart_c = (next_state != state);

    led_shift_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (tick_en_c),
        .restart (tick_restart_c),
        .tick    (tick)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            shift_reg    <= '0;
            last_sent    <= '0;
            bit_cnt      <= '0;
            init_pending <= 1'b1;
            ser          <= 1'b0;
            srclk        <= 1'b0;
            rclk         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= next_state;
            shift_reg    <= shift_d;
            last_sent    <= last_sent_d;
            bit_cnt      <= bit_cnt_d;
            init_pending <= init_d;
            ser          <= ser_d;
            srclk        <= srclk_d;
            rclk         <= rclk_d;
            busy         <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (start_c) next_state = SHIFT_LO;
            SHIFT_LO: if (tick) next_state = SHIFT_HI;
            SHIFT_HI: if (tick) next_state = (bit_cnt == LAST_BIT) ? LATCH_HI : SHIFT_LO;
            LATCH_HI: if (tick) next_state = LATCH_LO;
            LATCH_LO: if (tick) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Datapath and registered-output next values; shift_reg rotates so the
    // captured frame is intact again once every bit has been sent
    always_comb begin
        shift_d     = shift_reg;
        bit_cnt_d   = bit_cnt;
        last_sent_d = last_sent;
        init_d      = init_pending;
        unique case (state)
            IDLE: begin
                if (start_c) begin
                    shift_d   = data_in;
                    bit_cnt_d = '0;
                    init_d    = 1'b0;
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    if (MSB_FIRST) begin
                        shift_d = (shift_reg << 1) | (shift_reg >> (DATA_WIDTH - 1));
                    end else begin
                        shift_d = (shift_reg >> 1) | (shift_reg << (DATA_WIDTH - 1));
                    end
                    bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
                end
            end
            default: ;
        endcase

        if (next_state == LATCH_HI && state != LATCH_HI) begin
            last_sent_d = shift_d;
        end

        ser_d = 1'b0;
        if (next_state == SHIFT_LO || next_state == SHIFT_HI) begin
            ser_d = MSB_FIRST ? shift_d[DATA_WIDTH-1] : shift_d[0];
        end
        srclk_d = (next_state == SHIFT_HI);
        rclk_d  = (next_state == LATCH_HI);
        busy_d  = (next_state != IDLE);
    end

endmodule

// File: tb/tb_led_shift_out_driver.sv
// Bench for led_shift_out_driver: a 74HC595 chain model on the outputs plus
// frame-level expectations computed from the value being sent.
module tb_led_shift_out_driver;

    logic       clk;
    logic       reset_n;
    logic [7:0] data_in0;
    logic [7:0] data_in1;
    logic [1:0] ser_v, srclk_v, rclk_v, busy_v;

    int checks   = 0;
    int failures = 0;

    led_shift_out_driver dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .data_in (data_in0),
        .ser     (ser_v[0]),
        .srclk   (srclk_v[0]),
        .rclk    (rclk_v[0]),
        .busy    (busy_v[0])
    );

    led_shift_out_driver #(
        .DATA_WIDTH (8),
        .CLK_DIV    (1),
        .MSB_FIRST  (1'b0)
    ) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .data_in (data_in1),
        .ser     (ser_v[1]),
        .srclk   (srclk_v[1]),
        .rclk    (rclk_v[1]),
        .busy    (busy_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: shift-register chip model and cumulative event counters
    logic [1:0]  prev_srclk = '0, prev_rclk = '0, prev_busy = '0;
    int          busy_cyc[2]  = '{0, 0};
    int          rises[2]     = '{0, 0};
    int          lat_cnt[2]   = '{0, 0};
    int          hi_run[2]    = '{0, 0};
    int          hi_last[2]   = '{0, 0};
    int          hi_min[2]    = '{1000, 1000};
    int          hi_max[2]    = '{0, 0};
    int          rhi_run[2]   = '{0, 0};
    int          rhi_last[2]  = '{0, 0};
    int          idle_run[2]  = '{0, 0};
    int          gap_last[2]  = '{0, 0};
    logic [63:0] bits_acc[2]  = '{64'd0, 64'd0};
    logic [7:0]  chip_sr[2]   = '{8'd0, 8'd0};
    logic [7:0]  lat_last[2]  = '{8'd0, 8'd0};
    logic [7:0]  lat_prev[2]  = '{8'd0, 8'd0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (busy_v[i]) busy_cyc[i] <= busy_cyc[i] + 1;
            idle_run[i] <= busy_v[i] ? 0 : idle_run[i] + 1;
            if (busy_v[i] && !prev_busy[i]) gap_last[i] <= idle_run[i];
            hi_run[i]  <= srclk_v[i] ? hi_run[i] + 1 : 0;
            rhi_run[i] <= rclk_v[i] ? rhi_run[i] + 1 : 0;
            if (srclk_v[i] && !prev_srclk[i]) begin
                rises[i]    <= rises[i] + 1;
                bits_acc[i] <= {bits_acc[i][62:0], ser_v[i]};
                chip_sr[i]  <= {chip_sr[i][6:0], ser_v[i]};
            end
            if (!srclk_v[i] && prev_srclk[i]) begin
                hi_last[i] <= hi_run[i];
                if (hi_run[i] < hi_min[i]) hi_min[i] <= hi_run[i];
                if (hi_run[i] > hi_max[i]) hi_max[i] <= hi_run[i];
            end
            if (rclk_v[i] && !prev_rclk[i]) begin
                lat_cnt[i]  <= lat_cnt[i] + 1;
                lat_prev[i] <= lat_last[i];
                lat_last[i] <= chip_sr[i];
            end
            if (!rclk_v[i] && prev_rclk[i]) rhi_last[i] <= rhi_run[i];
        end
        prev_srclk <= srclk_v;
        prev_rclk  <= rclk_v;
        prev_busy  <= busy_v;
    end

    // Bits in transmit order, first bit in the MSB position; this is also what
    // the chain latches after a full frame
    function automatic logic [7:0] stream(input logic [7:0] v, input bit msb_first);
        logic [7:0] s;
        for (int k = 0; k < 8; k++) s[7-k] = msb_first ? v[7-k] : v[k];
        return s;
    endfunction

    function automatic int frame_len(input int width, input int div);
        return (2 * width + 2) * div;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Wait for busy to rise (if not already high) and then fall, bounded
    task automatic wait_done(input int i, input string tag);
        int n = 0;
        while (busy_v[i] !== 1'b1 && n < 400) begin step(); n++; end
        while (busy_v[i] !== 1'b0 && n < 400) begin step(); n++; end
        chk({tag, "_timeout"}, 64'(n < 400), 64'd1);
    endtask

    int         b_busy, b_rise, b_lat;
    logic [7:0] cur, v1, vmid, vfin;

    task automatic snap(input int i);
        b_busy = busy_cyc[i];
        b_rise = rises[i];
        b_lat  = lat_cnt[i];
    endtask

    initial begin
        reset_n  = 1'b0;
        data_in0 = 8'h00;
        data_in1 = 8'h00;
        repeat (3) step();
        chk("rst_ser",   64'(ser_v),   64'd0);
        chk("rst_srclk", 64'(srclk_v), 64'd0);
        chk("rst_rclk",  64'(rclk_v),  64'd0);
        chk("rst_busy",  64'(busy_v),  64'd0);

        // Initial frame after release even though data_in equals the reset last_sent
        snap(0);
        reset_n = 1'b1;
        step();
        chk("init_busy_rise", 64'(busy_v[0]), 64'd1);
        chk("init_srclk_lo",  64'(srclk_v[0]), 64'd0);
        wait_done(0, "init");
        chk("init_len",    64'(busy_cyc[0] - b_busy), 64'(frame_len(8, 4)));
        chk("init_rises",  64'(rises[0] - b_rise), 64'd8);
        chk("init_latch",  64'(lat_cnt[0] - b_lat), 64'd1);
        chk("init_rclk_w", 64'(rhi_last[0]), 64'd4);
        chk("init_value",  64'(lat_last[0]), 64'h00);
        cur = 8'h00;

        // 0xA5 MSB first
        snap(0);
        data_in0 = 8'hA5;
        wait_done(0, "a5");
        chk("a5_bits",    64'(bits_acc[0][7:0]), 64'(stream(8'hA5, 1'b1)));
        chk("a5_value",   64'(lat_last[0]), 64'hA5);
        chk("a5_len",     64'(busy_cyc[0] - b_busy), 64'(frame_len(8, 4)));
        chk("a5_srclk_w", 64'(hi_last[0]), 64'd4);
        cur = 8'hA5;

        // Unchanged value: chain stays quiet
        snap(0);
        repeat (1000) step();
        chk("hold_rises", 64'(rises[0] - b_rise), 64'd0);
        chk("hold_latch", 64'(lat_cnt[0] - b_lat), 64'd0);
        chk("hold_busy",  64'(busy_cyc[0] - b_busy), 64'd0);

        // Coalescing: 0x0F frame, then only the latest of 0x11/0x3C
        snap(0);
        data_in0 = 8'h0F;
        step();
        repeat (10) step();
        data_in0 = 8'h11;
        repeat (20) step();
        data_in0 = 8'h3C;
        wait_done(0, "coal1");
        wait_done(0, "coal2");
        repeat (100) step();
        chk("coal_bits",  64'(bits_acc[0][15:0]), 64'({stream(8'h0F, 1'b1), stream(8'h3C, 1'b1)}));
        chk("coal_first", 64'(lat_prev[0]), 64'h0F);
        chk("coal_last",  64'(lat_last[0]), 64'h3C);
        chk("coal_latch", 64'(lat_cnt[0] - b_lat), 64'd2);
        chk("coal_busy",  64'(busy_cyc[0] - b_busy), 64'(2 * frame_len(8, 4)));
        chk("coal_gap",   64'(gap_last[0]), 64'd1);
        cur = 8'h3C;

        // Randomised values with random mid-frame updates
        for (int it = 0; it < 4; it++) begin
            v1   = 8'($urandom_range(0, 255));
            if (v1 == cur) v1 = v1 ^ 8'h80;
            vmid = 8'($urandom_range(0, 255));
            vfin = 8'($urandom_range(0, 255));
            if (vfin == v1) vfin = vfin ^ 8'h01;
            snap(0);
            data_in0 = v1;
            step();
            repeat ($urandom_range(1, 30)) step();
            data_in0 = vmid;
            repeat ($urandom_range(1, 30)) step();
            data_in0 = vfin;
            wait_done(0, "rnd1");
            wait_done(0, "rnd2");
            repeat (5) step();
            chk("rnd_bits",  64'(bits_acc[0][15:0]), 64'({stream(v1, 1'b1), stream(vfin, 1'b1)}));
            chk("rnd_first", 64'(lat_prev[0]), 64'(v1));
            chk("rnd_last",  64'(lat_last[0]), 64'(vfin));
            chk("rnd_latch", 64'(lat_cnt[0] - b_lat), 64'd2);
            chk("rnd_busy",  64'(busy_cyc[0] - b_busy), 64'(2 * frame_len(8, 4)));
            cur = vfin;
        end

        // Reset in the middle of a 0xFF frame, then full resend
        begin
            int n = 0;
            snap(0);
            data_in0 = 8'hFF;
            while ((rises[0] - b_rise) < 4 && n < 400) begin step(); n++; end
            chk("mid_reach_bit4", 64'(n < 400), 64'd1);
        end
        reset_n = 1'b0;
        #1;
        chk("mid_ser",   64'(ser_v[0]),   64'd0);
        chk("mid_srclk", 64'(srclk_v[0]), 64'd0);
        chk("mid_rclk",  64'(rclk_v[0]),  64'd0);
        chk("mid_busy",  64'(busy_v[0]),  64'd0);
        repeat (2) step();
        snap(0);
        reset_n = 1'b1;
        wait_done(0, "resend");
        chk("resend_value", 64'(lat_last[0]), 64'hFF);
        chk("resend_rises", 64'(rises[0] - b_rise), 64'd8);
        chk("resend_len",   64'(busy_cyc[0] - b_busy), 64'(frame_len(8, 4)));

        // CLK_DIV=1, LSB first
        begin
            int n = 0;
            while (busy_v[1] !== 1'b0 && n < 100) begin step(); n++; end
            chk("d1_idle", 64'(n < 100), 64'd1);
        end
        snap(1);
        data_in1 = 8'h01;
        wait_done(1, "d1");
        chk("d1_len",       64'(busy_cyc[1] - b_busy), 64'(frame_len(8, 1)));
        chk("d1_first_bit", 64'(bits_acc[1][7]), 64'd1);
        chk("d1_bits",      64'(bits_acc[1][7:0]), 64'(stream(8'h01, 1'b0)));
        chk("d1_latched",   64'(lat_last[1]), 64'(stream(8'h01, 1'b0)));
        chk("d1_hi_min",    64'(hi_min[1]), 64'd1);
        chk("d1_hi_max",    64'(hi_max[1]), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
